// File: rtl/inst_cache_pkg.sv
// Shared types for the direct-mapped instruction cache: geometry, array
// element types and the controller state encoding.
package icache_types;

    localparam int S_INDEX  = 4;
    localparam int S_OFFSET = 5;
    localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
    localparam int S_LINE   = 256;

    typedef logic [S_TAG-1:0]   icache_tag_t;
    typedef logic [S_INDEX-1:0] icache_index_t;
    typedef logic [S_LINE-1:0]  icache_line_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read
// port addressed by the fetch index, one synchronous write port for fills.
module icache_array #(
    parameter int S_INDEX = icache_types::S_INDEX,
    parameter int S_TAG   = icache_types::S_TAG,
    parameter int S_LINE  = icache_types::S_LINE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] rd_index,
    output logic               rd_valid,
    output logic [S_TAG-1:0]   rd_tag,
    output logic [S_LINE-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [S_INDEX-1:0] wr_index,
    input  logic [S_TAG-1:0]   wr_tag,
    input  logic [S_LINE-1:0]  wr_line
);

    localparam int SETS = 2 ** S_INDEX;

    logic [SETS-1:0]   valid;
    logic [S_TAG-1:0]  tags  [SETS];
    logic [S_LINE-1:0] lines [SETS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = lines[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-line
// fills from the physical-memory line port on a miss.
module inst_cache #(
    parameter int S_INDEX  = icache_types::S_INDEX,
    parameter int S_OFFSET = icache_types::S_OFFSET
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inst_read,
    input  logic [31:0]                 inst_addr,
    output logic                        inst_resp,
    output logic [31:0]                 inst_rdata,
    output logic                        pmem_read,
    output logic [31:0]                 pmem_address,
    input  logic [(8<<S_OFFSET)-1:0]    pmem_rdata,
    input  logic                        pmem_resp,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count,
    output icache_types::icache_state_t dbg_state
);

    localparam int S_TAG  = 32 - S_INDEX - S_OFFSET;
    localparam int LINE_W = 8 << S_OFFSET;

    icache_types::icache_state_t state, state_next;

    logic [S_TAG-1:0]      addr_tag;
    logic [S_INDEX-1:0]    addr_index;
    logic [S_OFFSET-3:0]   addr_word;
    logic [31-S_OFFSET:0]  fill_addr;
    logic                  rd_valid;
    logic [S_TAG-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  hit;
    logic                  start_fill;
    logic                  fill_we;
    logic [1:0]            unused_byte_sel;

    assign addr_tag        = inst_addr[31:S_INDEX+S_OFFSET];
    assign addr_index      = inst_addr[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign addr_word       = inst_addr[S_OFFSET-1:2];
    assign unused_byte_sel = inst_addr[1:0];

    icache_array #(
        .S_INDEX (S_INDEX),
        .S_TAG   (S_TAG),
        .S_LINE  (LINE_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (addr_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (fill_we),
        .wr_index (fill_addr[S_INDEX-1:0]),
        .wr_tag   (fill_addr[31-S_OFFSET:S_INDEX]),
        .wr_line  (pmem_rdata)
    );

    assign hit       = inst_read && rd_valid && (rd_tag == addr_tag);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= icache_types::IDLE;
            fill_addr <= '0;
        end else begin
            state <= state_next;
            if (start_fill) begin
                fill_addr <= inst_addr[31:S_OFFSET];
            end
        end
    end

    // The fill address is latched, so a redirect during FILL never retargets it.
    always_comb begin
        state_next   = state;
        inst_resp    = 1'b0;
        inst_rdata   = '0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        start_fill   = 1'b0;
        fill_we      = 1'b0;
        case (state)
            icache_types::IDLE: begin
                if (hit) begin
                    inst_resp  = 1'b1;
                    inst_rdata = rd_line[32*addr_word +: 32];
                end else if (inst_read) begin
                    start_fill = 1'b1;
                    state_next = icache_types::FILL;
                end
            end
            icache_types::FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {fill_addr, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    fill_we    = 1'b1;
                    state_next = icache_types::IDLE;
                end
            end
            default: state_next = icache_types::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (inst_resp && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: each task drives one scenario and checks
// outputs one time unit after driving, well away from the rising edge.
module tb_inst_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inst_read = 1'b0;
    logic [31:0]  inst_addr = '0;
    logic         inst_resp;
    logic [31:0]  inst_rdata;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
    icache_types::icache_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    inst_cache dut (
        .clk          (clk),
        .rst          (rst),
        .inst_read    (inst_read),
        .inst_addr    (inst_addr),
        .inst_resp    (inst_resp),
        .inst_rdata   (inst_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory image: word at byte address a holds a ^ 32'hA5A5_0000.
    function automatic logic [255:0] line_for(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = (base + 32'(4*k)) ^ 32'hA5A5_0000;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; inst_read = 1'b0; pmem_resp = 1'b0;
        tick(); tick();
        n_tests++; if (dbg_state !== icache_types::IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_tests++; if ({inst_resp, pmem_read} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {inst_resp, pmem_read}); end
        n_tests++; if (inst_rdata !== 32'h0 || pmem_address !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", inst_rdata, pmem_address); end
        n_tests++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        inst_read = 1'b1; inst_addr = 32'h0000_0064;
        #1;
        n_tests++; if (inst_resp !== 1'b0 || pmem_read !== 1'b0) begin n_fail++; $display("FAIL cold_c0: got resp=%b pread=%b want 0/0", inst_resp, pmem_read); end
        tick();
        n_tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0060) begin n_fail++; $display("FAIL cold_c1: got pread=%b addr=%h want 1/00000060", pmem_read, pmem_address); end
        n_tests++; if (miss_count !== 32'd1 || inst_resp !== 1'b0) begin n_fail++; $display("FAIL cold_cnt: got miss=%0d resp=%b want 1/0", miss_count, inst_resp); end
        tick();
        n_tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0060) begin n_fail++; $display("FAIL cold_c2: got pread=%b addr=%h want 1/00000060", pmem_read, pmem_address); end
        tick();
        pmem_resp = 1'b1; pmem_rdata = line_for(32'h0000_0060);
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        #1;
        n_tests++; if (inst_resp !== 1'b1 || inst_rdata !== 32'hA5A5_0064) begin n_fail++; $display("FAIL cold_hit: got resp=%b data=%h want 1/a5a50064", inst_resp, inst_rdata); end
        n_tests++; if (pmem_read !== 1'b0 || dbg_state !== icache_types::IDLE) begin n_fail++; $display("FAIL cold_drop: got pread=%b state=%0d want 0/0", pmem_read, dbg_state); end
    endtask

    // Starts in the hit cycle left by test_cold_miss; that cycle's address is
    // replaced before the edge so exactly eight hits are counted.
    task automatic test_streaming_hits();
        for (int i = 0; i < 8; i++) begin
            inst_read = 1'b1; inst_addr = 32'h60 + 32'(4*i);
            #1;
            n_tests++; if (inst_resp !== 1'b1 || inst_rdata !== (32'hA5A5_0060 + 32'(4*i)) || pmem_read !== 1'b0) begin
                n_fail++; $display("FAIL stream_%0d: got resp=%b data=%h pread=%b want 1/%h/0", i, inst_resp, inst_rdata, pmem_read, 32'hA5A5_0060 + 32'(4*i));
            end
            tick();
        end
        inst_read = 1'b0;
        #1;
        n_tests++; if (hit_count !== 32'd8 || miss_count !== 32'd1) begin n_fail++; $display("FAIL stream_cnt: got hit=%0d miss=%0d want 8/1", hit_count, miss_count); end
    endtask

    // Miss, fill after lat cycles of pmem_read, then check the hit and drop
    // inst_read before the edge so the hit is not counted.
    task automatic run_miss(input logic [31:0] addr, input int lat, input logic [31:0] exp_word);
        inst_read = 1'b1; inst_addr = addr;
        #1;
        n_tests++; if (inst_resp !== 1'b0) begin n_fail++; $display("FAIL miss_%h_c0: got resp=%b want 0", addr, inst_resp); end
        tick();
        n_tests++; if (pmem_read !== 1'b1 || pmem_address !== {addr[31:5], 5'b0}) begin n_fail++; $display("FAIL miss_%h_req: got pread=%b addr=%h want 1/%h", addr, pmem_read, pmem_address, {addr[31:5], 5'b0}); end
        repeat (lat - 1) tick();
        pmem_resp = 1'b1; pmem_rdata = line_for({addr[31:5], 5'b0});
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        #1;
        n_tests++; if (inst_resp !== 1'b1 || inst_rdata !== exp_word || pmem_read !== 1'b0) begin n_fail++; $display("FAIL miss_%h_hit: got resp=%b data=%h pread=%b want 1/%h/0", addr, inst_resp, inst_rdata, pmem_read, exp_word); end
        inst_read = 1'b0;
        #1;
    endtask

    task automatic test_conflict_eviction();
        run_miss(32'h0000_0000, 2, 32'hA5A5_0000);
        run_miss(32'h0000_0200, 2, 32'hA5A5_0200);
        run_miss(32'h0000_0004, 3, 32'hA5A5_0004);
        n_tests++; if (miss_count !== 32'd4 || hit_count !== 32'd8) begin n_fail++; $display("FAIL conflict_cnt: got miss=%0d hit=%0d want 4/8", miss_count, hit_count); end
    endtask

    task automatic test_redirect_during_fill();
        inst_read = 1'b1; inst_addr = 32'h0000_0100;
        tick();
        inst_addr = 32'h0000_0400;
        #1;
        n_tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_hold: got pread=%b addr=%h want 1/00000100", pmem_read, pmem_address); end
        tick();
        pmem_resp = 1'b1; pmem_rdata = line_for(32'h0000_0100);
        #1;
        n_tests++; if (pmem_address !== 32'h0000_0100 || inst_resp !== 1'b0) begin n_fail++; $display("FAIL redir_resp: got addr=%h resp=%b want 00000100/0", pmem_address, inst_resp); end
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        #1;
        n_tests++; if (dbg_state !== icache_types::IDLE || inst_resp !== 1'b0 || pmem_read !== 1'b0) begin n_fail++; $display("FAIL redir_idle: got state=%0d resp=%b pread=%b want 0/0/0", dbg_state, inst_resp, pmem_read); end
        tick();
        n_tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0400) begin n_fail++; $display("FAIL redir_refill: got pread=%b addr=%h want 1/00000400", pmem_read, pmem_address); end
        pmem_resp = 1'b1; pmem_rdata = line_for(32'h0000_0400);
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        #1;
        n_tests++; if (inst_resp !== 1'b1 || inst_rdata !== 32'hA5A5_0400) begin n_fail++; $display("FAIL redir_hit400: got resp=%b data=%h want 1/a5a50400", inst_resp, inst_rdata); end
        inst_addr = 32'h0000_0108;
        #1;
        n_tests++; if (inst_resp !== 1'b1 || inst_rdata !== 32'hA5A5_0108) begin n_fail++; $display("FAIL redir_hit100: got resp=%b data=%h want 1/a5a50108", inst_resp, inst_rdata); end
        inst_read = 1'b0;
        #1;
        n_tests++; if (miss_count !== 32'd6 || hit_count !== 32'd8) begin n_fail++; $display("FAIL redir_cnt: got miss=%0d hit=%0d want 6/8", miss_count, hit_count); end
    endtask

    task automatic test_reset_mid_fill();
        inst_read = 1'b1; inst_addr = 32'h0000_0800;
        tick();
        n_tests++; if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL rstfill_req: got pread=%b want 1", pmem_read); end
        rst = 1'b0;
        tick();
        rst = 1'b1; inst_read = 1'b0;
        #1;
        n_tests++; if (pmem_read !== 1'b0 || dbg_state !== icache_types::IDLE) begin n_fail++; $display("FAIL rstfill_idle: got pread=%b state=%0d want 0/0", pmem_read, dbg_state); end
        n_tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_fail++; $display("FAIL rstfill_cnt: got hit=%0d miss=%0d want 0/0", hit_count, miss_count); end
        pmem_resp = 1'b1; pmem_rdata = line_for(32'h0000_0800);
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        inst_read = 1'b1;
        #1;
        n_tests++; if (inst_resp !== 1'b0) begin n_fail++; $display("FAIL rstfill_late: got resp=%b want 0", inst_resp); end
        tick();
        n_tests++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0800 || miss_count !== 32'd1) begin n_fail++; $display("FAIL rstfill_again: got pread=%b addr=%h miss=%0d want 1/00000800/1", pmem_read, pmem_address, miss_count); end
        pmem_resp = 1'b1; pmem_rdata = line_for(32'h0000_0800);
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        #1;
        n_tests++; if (inst_resp !== 1'b1 || inst_rdata !== 32'hA5A5_0800) begin n_fail++; $display("FAIL rstfill_hit: got resp=%b data=%h want 1/a5a50800", inst_resp, inst_rdata); end
        inst_addr = 32'h0000_0060;
        #1;
        n_tests++; if (inst_resp !== 1'b0) begin n_fail++; $display("FAIL rstfill_cleared: got resp=%b want 0", inst_resp); end
        inst_read = 1'b0;
        #1;
    endtask

    task automatic test_idle_spurious();
        inst_read = 1'b0; inst_addr = 32'h0000_0800;
        #1;
        n_tests++; if (inst_resp !== 1'b0 || inst_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_quiet: got resp=%b data=%h want 0/00000000", inst_resp, inst_rdata); end
        pmem_resp = 1'b1; pmem_rdata = {8{32'hDEAD_BEEF}};
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        #1;
        n_tests++; if (pmem_read !== 1'b0 || dbg_state !== icache_types::IDLE) begin n_fail++; $display("FAIL idle_spur_state: got pread=%b state=%0d want 0/0", pmem_read, dbg_state); end
        inst_read = 1'b1; inst_addr = 32'h0000_081C;
        #1;
        n_tests++; if (inst_resp !== 1'b1 || inst_rdata !== 32'hA5A5_081C) begin n_fail++; $display("FAIL idle_spur_data: got resp=%b data=%h want 1/a5a5081c", inst_resp, inst_rdata); end
        tick();
        inst_read = 1'b0;
        #1;
        n_tests++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin n_fail++; $display("FAIL idle_cnt: got hit=%0d miss=%0d want 1/1", hit_count, miss_count); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_streaming_hits();
        test_conflict_eviction();
        test_redirect_during_fill();
        test_reset_mid_fill();
        test_idle_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
